// File: rtl/pipe_ctrl.sv
// Control unit for a classic five-stage MIPS-style pipeline.
//
// Decodes the instruction in IF/ID and carries its control bits through the
// ID/EX, EX/MEM and MEM/WB control registers. It detects load-use and
// no-forwarding RAW hazards, handles jumps resolved in ID and taken branches
// resolved in EX, selects EX operand forwarding, and counts stall and flush
// cycles.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   id_instr, id_valid  instruction in IF/ID and its valid flag (0 = bubble)
//   ex_taken            branch condition from the EX datapath
//   stall               hold PC and IF/ID
//   flush_ifid          squash IF/ID on the next edge
//   id_jump, id_jr      redirect PC from ID; id_jr selects rs data as target
//   ex_alu_ctrl         ALU command (add 000, sub 001, xor 010, slt 011)
//   ex_alu_src          ALU B source (1 = immediate, 0 = rt data)
//   ex_beq, ex_bne      branch type of the instruction in EX
//   ex_fwd_a, ex_fwd_b  operand source (00 regfile, 01 EX/MEM, 10 MEM/WB)
//   mem_wr              data-memory write for the instruction in MEM
//   wb_reg_wr, wb_waddr register write enable and address in WB
//   wb_mem_to_reg       WB data comes from memory
//   wb_link             WB data is PC+4 (JAL)
//   illegal             one-cycle pulse for an unsupported instruction in ID
//   stall_cnt, flush_cnt saturating event counters

module pipe_ctrl #(
    parameter bit          FWD_EN   = 1'b1,
    parameter int unsigned LINK_REG = 31,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      id_instr,
    input  logic             id_valid,
    input  logic             ex_taken,
    output logic             stall,
    output logic             flush_ifid,
    output logic             id_jump,
    output logic             id_jr,
    output logic [2:0]       ex_alu_ctrl,
    output logic             ex_alu_src,
    output logic             ex_beq,
    output logic             ex_bne,
    output logic [1:0]       ex_fwd_a,
    output logic [1:0]       ex_fwd_b,
    output logic             mem_wr,
    output logic             wb_reg_wr,
    output logic [4:0]       wb_waddr,
    output logic             wb_mem_to_reg,
    output logic             wb_link,
    output logic             illegal,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2a;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // waddr is kept at 0 whenever reg_wr is 0, so address compares alone
    // are enough once register 0 is excluded.
    typedef struct packed {
        logic       reg_wr;
        logic [4:0] waddr;
        logic       mem_rd;
        logic       mem_wr;
        logic       mem_to_reg;
        logic       link;
        logic [2:0] alu_ctrl;
        logic       alu_src;
        logic       beq;
        logic       bne;
        logic [4:0] rs;
        logic [4:0] rt;
    } idex_t;

    typedef struct packed {
        logic       reg_wr;
        logic [4:0] waddr;
        logic       mem_wr;
        logic       mem_to_reg;
        logic       link;
    } exmem_t;

    typedef struct packed {
        logic       reg_wr;
        logic [4:0] waddr;
        logic       mem_to_reg;
        logic       link;
    } memwb_t;

    idex_t  idex_q, idex_d;
    exmem_t exmem_q, exmem_d;
    memwb_t memwb_q, memwb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    idex_t dec;
    logic  legal;
    logic  use_rs;
    logic  use_rt;
    logic  dec_jump;
    logic  dec_jr;
    logic  branch_flush;
    logic  hazard;
    logic  stall_int;
    logic  jump_int;
    logic  flush_int;
    logic  illegal_int;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_shamt;

    assign opcode       = id_instr[31:26];
    assign funct        = id_instr[5:0];
    assign unused_shamt = ^id_instr[10:6];

    // True when r is a real register that one of the pending dests will write.
    function automatic logic hits(input logic [4:0] r, input logic [4:0] a,
                                  input logic [4:0] b, input logic [4:0] c);
        return (r != 5'd0) && ((r == a) || (r == b) || (r == c));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] r,
                                           input logic [4:0] em_waddr,
                                           input logic [4:0] mw_waddr);
        if (!FWD_EN || r == 5'd0) begin
            return 2'b00;
        end else if (r == em_waddr) begin
            return 2'b01;
        end else if (r == mw_waddr) begin
            return 2'b10;
        end
        return 2'b00;
    endfunction

    // ID decode
    always_comb begin
        dec      = '0;
        legal    = 1'b1;
        use_rs   = 1'b0;
        use_rt   = 1'b0;
        dec_jump = 1'b0;
        dec_jr   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_JR: begin
                        dec_jump = 1'b1;
                        dec_jr   = 1'b1;
                        use_rs   = 1'b1;
                    end
                    FN_ADD, FN_SUB, FN_SLT: begin
                        dec.reg_wr   = 1'b1;
                        dec.waddr    = id_instr[15:11];
                        dec.alu_ctrl = (funct == FN_ADD) ? ALU_ADD :
                                       (funct == FN_SUB) ? ALU_SUB : ALU_SLT;
                        use_rs       = 1'b1;
                        use_rt       = 1'b1;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_LW: begin
                dec.reg_wr     = 1'b1;
                dec.waddr      = id_instr[20:16];
                dec.mem_rd     = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.alu_src    = 1'b1;
                use_rs         = 1'b1;
            end
            OP_SW: begin
                dec.mem_wr  = 1'b1;
                dec.alu_src = 1'b1;
                use_rs      = 1'b1;
                use_rt      = 1'b1;
            end
            OP_J: dec_jump = 1'b1;
            OP_JAL: begin
                dec_jump   = 1'b1;
                dec.reg_wr = 1'b1;
                dec.waddr  = 5'(LINK_REG);
                dec.link   = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec.beq      = (opcode == OP_BEQ);
                dec.bne      = (opcode == OP_BNE);
                dec.alu_ctrl = ALU_SUB;
                use_rs       = 1'b1;
                use_rt       = 1'b1;
            end
            OP_XORI, OP_ADDI: begin
                dec.reg_wr   = 1'b1;
                dec.waddr    = id_instr[20:16];
                dec.alu_ctrl = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
                dec.alu_src  = 1'b1;
                use_rs       = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        if (!id_valid || !legal) begin
            dec      = '0;
            use_rs   = 1'b0;
            use_rt   = 1'b0;
            dec_jump = 1'b0;
            dec_jr   = 1'b0;
        end
        // A write to register 0 is carried as a non-writing instruction.
        if (dec.waddr == 5'd0) begin
            dec.reg_wr = 1'b0;
        end
        if (!dec.reg_wr) begin
            dec.waddr = 5'd0;
        end
        // Unused sources are zeroed so they never match a hazard or forward.
        dec.rs = use_rs ? id_instr[25:21] : 5'd0;
        dec.rt = use_rt ? id_instr[20:16] : 5'd0;
    end

    // Hazards, redirects and pipeline advance
    always_comb begin
        branch_flush = (idex_q.beq | idex_q.bne) & ex_taken;

        hazard = 1'b0;
        if (FWD_EN) begin
            if (idex_q.mem_rd && idex_q.reg_wr) begin
                hazard = hits(dec.rs, idex_q.waddr, 5'd0, 5'd0) |
                         hits(dec.rt, idex_q.waddr, 5'd0, 5'd0);
            end
        end else begin
            hazard = hits(dec.rs, idex_q.waddr, exmem_q.waddr, memwb_q.waddr) |
                     hits(dec.rt, idex_q.waddr, exmem_q.waddr, memwb_q.waddr);
        end
        // JR reads rs in ID, where no forwarding path exists.
        if (dec_jr && hits(dec.rs, idex_q.waddr, exmem_q.waddr, memwb_q.waddr)) begin
            hazard = 1'b1;
        end

        stall_int   = hazard & ~branch_flush;
        jump_int    = dec_jump & ~branch_flush & ~hazard;
        flush_int   = branch_flush | jump_int;
        illegal_int = id_valid & ~legal & ~branch_flush;

        idex_d = (branch_flush || hazard) ? '0 : dec;

        exmem_d.reg_wr     = idex_q.reg_wr;
        exmem_d.waddr      = idex_q.waddr;
        exmem_d.mem_wr     = idex_q.mem_wr;
        exmem_d.mem_to_reg = idex_q.mem_to_reg;
        exmem_d.link       = idex_q.link;

        memwb_d.reg_wr     = exmem_q.reg_wr;
        memwb_d.waddr      = exmem_q.waddr;
        memwb_d.mem_to_reg = exmem_q.mem_to_reg;
        memwb_d.link       = exmem_q.link;

        stall_cnt_d = stall_cnt_q;
        if (stall_int && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        flush_cnt_d = flush_cnt_q;
        if (flush_int && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q      <= '0;
            exmem_q     <= '0;
            memwb_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            idex_q      <= idex_d;
            exmem_q     <= exmem_d;
            memwb_q     <= memwb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // ID-stage outputs are combinational from id_instr, so they are held low
    // while reset is asserted; registered outputs are already cleared.
    assign stall      = rst_n & stall_int;
    assign flush_ifid = rst_n & flush_int;
    assign id_jump    = rst_n & jump_int;
    assign id_jr      = rst_n & jump_int & dec_jr;
    assign illegal    = rst_n & illegal_int;

    assign ex_alu_ctrl = idex_q.alu_ctrl;
    assign ex_alu_src  = idex_q.alu_src;
    assign ex_beq      = idex_q.beq;
    assign ex_bne      = idex_q.bne;
    assign ex_fwd_a    = fwd_sel(idex_q.rs, exmem_q.waddr, memwb_q.waddr);
    assign ex_fwd_b    = fwd_sel(idex_q.rt, exmem_q.waddr, memwb_q.waddr);

    assign mem_wr        = exmem_q.mem_wr;
    assign wb_reg_wr     = memwb_q.reg_wr;
    assign wb_waddr      = memwb_q.waddr;
    assign wb_mem_to_reg = memwb_q.mem_to_reg;
    assign wb_link       = memwb_q.link;

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
`timescale 1ns/1ps
module tb_pipe_ctrl;

    localparam logic [5:0] OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2b;
    localparam logic [5:0] FN_JR = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22;

    typedef struct packed {
        logic       stall;
        logic       flush_ifid;
        logic       id_jump;
        logic       id_jr;
        logic [2:0] ex_alu_ctrl;
        logic       ex_alu_src;
        logic       ex_beq;
        logic       ex_bne;
        logic [1:0] ex_fwd_a;
        logic [1:0] ex_fwd_b;
        logic       mem_wr;
        logic       wb_reg_wr;
        logic [4:0] wb_waddr;
        logic       wb_mem_to_reg;
        logic       wb_link;
        logic       illegal;
    } dut_out_t;

    typedef struct {
        int         due;
        logic [7:0] wb;  // {reg_wr, link, mem_to_reg, waddr}
        logic       mw;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] id_instr = '0;
    logic        id_valid = 1'b0;
    logic        ex_taken = 1'b0;

    dut_out_t    d, n, s;
    logic [15:0] d_scnt, d_fcnt, n_scnt, n_fcnt;
    logic [1:0]  s_scnt, s_fcnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [7:0] wb_log [0:1023];
    logic       mem_log [0:1023];
    exp_t sb[$];

    always #5 clk = ~clk;

    pipe_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
        .ex_taken(ex_taken), .stall(d.stall), .flush_ifid(d.flush_ifid),
        .id_jump(d.id_jump), .id_jr(d.id_jr), .ex_alu_ctrl(d.ex_alu_ctrl),
        .ex_alu_src(d.ex_alu_src), .ex_beq(d.ex_beq), .ex_bne(d.ex_bne),
        .ex_fwd_a(d.ex_fwd_a), .ex_fwd_b(d.ex_fwd_b), .mem_wr(d.mem_wr),
        .wb_reg_wr(d.wb_reg_wr), .wb_waddr(d.wb_waddr), .wb_mem_to_reg(d.wb_mem_to_reg),
        .wb_link(d.wb_link), .illegal(d.illegal), .stall_cnt(d_scnt), .flush_cnt(d_fcnt)
    );

    pipe_ctrl #(.FWD_EN(1'b0)) u_nofwd (
        .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
        .ex_taken(ex_taken), .stall(n.stall), .flush_ifid(n.flush_ifid),
        .id_jump(n.id_jump), .id_jr(n.id_jr), .ex_alu_ctrl(n.ex_alu_ctrl),
        .ex_alu_src(n.ex_alu_src), .ex_beq(n.ex_beq), .ex_bne(n.ex_bne),
        .ex_fwd_a(n.ex_fwd_a), .ex_fwd_b(n.ex_fwd_b), .mem_wr(n.mem_wr),
        .wb_reg_wr(n.wb_reg_wr), .wb_waddr(n.wb_waddr), .wb_mem_to_reg(n.wb_mem_to_reg),
        .wb_link(n.wb_link), .illegal(n.illegal), .stall_cnt(n_scnt), .flush_cnt(n_fcnt)
    );

    pipe_ctrl #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
        .ex_taken(ex_taken), .stall(s.stall), .flush_ifid(s.flush_ifid),
        .id_jump(s.id_jump), .id_jr(s.id_jr), .ex_alu_ctrl(s.ex_alu_ctrl),
        .ex_alu_src(s.ex_alu_src), .ex_beq(s.ex_beq), .ex_bne(s.ex_bne),
        .ex_fwd_a(s.ex_fwd_a), .ex_fwd_b(s.ex_fwd_b), .mem_wr(s.mem_wr),
        .wb_reg_wr(s.wb_reg_wr), .wb_waddr(s.wb_waddr), .wb_mem_to_reg(s.wb_mem_to_reg),
        .wb_link(s.wb_link), .illegal(s.illegal), .stall_cnt(s_scnt), .flush_cnt(s_fcnt)
    );

    // Cycle index and a record of the default DUT's MEM/WB outputs per cycle.
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        wb_log[cyc % 1024]  <= {d.wb_reg_wr, d.wb_link, d.wb_mem_to_reg, d.wb_waddr};
        mem_log[cyc % 1024] <= d.mem_wr;
    end

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                          input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    task automatic issue(input logic [31:0] instr, input logic valid, input logic taken);
        @(negedge clk);
        id_instr = instr;
        id_valid = valid;
        ex_taken = taken;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        id_valid = 1'b0;
        ex_taken = 1'b0;
        id_instr = '0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        dut_out_t zero;
        zero = '0;
        rst_n = 1'b0;
        id_instr = {OP_JAL, 26'h10};
        id_valid = 1'b1;
        ex_taken = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (d !== zero || d_scnt !== 16'd0 || d_fcnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h cnt=%0d/%0d exp=0", d, d_scnt, d_fcnt);
        end
        id_instr = 32'hfc00_0000;
        #1;
        checks++;
        if (d.illegal !== 1'b0) begin
            failures++;
            $display("FAIL reset_illegal got=%b exp=0", d.illegal);
        end
        id_instr = {OP_JAL, 26'h10};
        rst_n = 1'b1;
        #1;
        checks++;
        if (d.id_jump !== 1'b1 || d.flush_ifid !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_decode got=%b%b exp=11", d.id_jump, d.flush_ifid);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        issue(itype(OP_LW, 1, 2, 16'h0), 1'b1, 1'b0);
        checks++;
        if (d.stall !== 1'b0) begin
            failures++; $display("FAIL lu_lw_nostall got=%b exp=0", d.stall);
        end
        issue(rtype(2, 4, 3, FN_ADD), 1'b1, 1'b0);
        checks++;
        if (d.stall !== 1'b1) begin
            failures++; $display("FAIL lu_stall got=%b exp=1", d.stall);
        end
        issue(rtype(2, 4, 3, FN_ADD), 1'b1, 1'b0);
        checks++;
        if (d.stall !== 1'b0) begin
            failures++; $display("FAIL lu_release got=%b exp=0", d.stall);
        end
        issue('0, 1'b0, 1'b0);
        checks++;
        if (d.ex_fwd_a !== 2'b10 || d.ex_fwd_b !== 2'b00) begin
            failures++;
            $display("FAIL lu_fwd got=%b/%b exp=10/00", d.ex_fwd_a, d.ex_fwd_b);
        end
        checks++;
        if (d_scnt !== 16'd1) begin
            failures++; $display("FAIL lu_stall_cnt got=%0d exp=1", d_scnt);
        end
    endtask

    task automatic test_forward();
        int nstalls;
        do_reset();
        issue(rtype(1, 1, 5, FN_ADD), 1'b1, 1'b0);
        issue(rtype(5, 5, 6, FN_SUB), 1'b1, 1'b0);
        checks++;
        if (d.stall !== 1'b0) begin
            failures++; $display("FAIL fwd_nostall got=%b exp=0", d.stall);
        end
        issue(rtype(2, 2, 8, FN_ADD), 1'b1, 1'b0);
        checks++;
        if (d.ex_fwd_a !== 2'b01 || d.ex_fwd_b !== 2'b01) begin
            failures++;
            $display("FAIL fwd_exmem got=%b/%b exp=01/01", d.ex_fwd_a, d.ex_fwd_b);
        end
        issue(rtype(6, 8, 7, FN_SUB), 1'b1, 1'b0);
        issue('0, 1'b0, 1'b0);
        checks++;
        if (d.ex_fwd_a !== 2'b10 || d.ex_fwd_b !== 2'b01) begin
            failures++;
            $display("FAIL fwd_mixed got=%b/%b exp=10/01", d.ex_fwd_a, d.ex_fwd_b);
        end
        // Without forwarding the consumer waits for the producer to leave WB.
        do_reset();
        issue(rtype(1, 1, 5, FN_ADD), 1'b1, 1'b0);
        issue(rtype(5, 5, 6, FN_SUB), 1'b1, 1'b0);
        nstalls = 0;
        for (int i = 0; i < 8 && n.stall === 1'b1; i++) begin
            nstalls++;
            issue(rtype(5, 5, 6, FN_SUB), 1'b1, 1'b0);
        end
        checks++;
        if (nstalls !== 3) begin
            failures++; $display("FAIL nofwd_stall_cycles got=%0d exp=3", nstalls);
        end
        checks++;
        if (n_scnt !== 16'd3) begin
            failures++; $display("FAIL nofwd_stall_cnt got=%0d exp=3", n_scnt);
        end
    endtask

    task automatic test_branch();
        exp_t e;
        do_reset();
        issue(itype(OP_LW, 1, 2, 16'h0), 1'b1, 1'b0);
        sb.push_back('{cyc + 3, 8'b1010_0010, 1'b0});
        issue(itype(OP_BEQ, 7, 8, 16'h4), 1'b1, 1'b1);
        sb.push_back('{cyc + 3, 8'h00, 1'b0});
        checks++;
        if (d.flush_ifid !== 1'b0 || d.stall !== 1'b0) begin
            failures++;
            $display("FAIL taken_ignored got=%b%b exp=00", d.flush_ifid, d.stall);
        end
        issue(rtype(2, 4, 3, FN_ADD), 1'b1, 1'b1);
        sb.push_back('{cyc + 3, 8'h00, 1'b0});
        checks++;
        if (d.flush_ifid !== 1'b1 || d.stall !== 1'b0 || d.id_jump !== 1'b0) begin
            failures++;
            $display("FAIL br_flush got=%b%b%b exp=100", d.flush_ifid, d.stall, d.id_jump);
        end
        checks++;
        if (n.flush_ifid !== 1'b1 || n.stall !== 1'b0) begin
            failures++;
            $display("FAIL br_over_stall got=%b%b exp=10", n.flush_ifid, n.stall);
        end
        issue(itype(OP_BNE, 1, 2, 16'h8), 1'b1, 1'b0);
        checks++;
        if (d_fcnt !== 16'd1 || d_scnt !== 16'd0 || n_scnt !== 16'd0 || d.ex_beq !== 1'b0) begin
            failures++;
            $display("FAIL br_counts got=%0d/%0d/%0d beq=%b exp=1/0/0 beq=0",
                     d_fcnt, d_scnt, n_scnt, d.ex_beq);
        end
        issue('0, 1'b0, 1'b0);
        checks++;
        if (d.ex_bne !== 1'b1 || d.ex_alu_ctrl !== 3'b001 || d.ex_alu_src !== 1'b0) begin
            failures++;
            $display("FAIL bne_decode got=%b/%b/%b exp=1/001/0",
                     d.ex_bne, d.ex_alu_ctrl, d.ex_alu_src);
        end
        repeat (5) @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (wb_log[e.due % 1024] !== e.wb || mem_log[(e.due - 1) % 1024] !== e.mw) begin
                failures++;
                $display("FAIL br_wb due=%0d got=%b/%b exp=%b/%b", e.due,
                         wb_log[e.due % 1024], mem_log[(e.due - 1) % 1024], e.wb, e.mw);
            end
        end
    endtask

    task automatic test_jump();
        exp_t e;
        int   jstalls;
        logic early;
        do_reset();
        issue({OP_JAL, 26'h10}, 1'b1, 1'b0);
        sb.push_back('{cyc + 3, 8'b1101_1111, 1'b0});
        checks++;
        if (d.id_jump !== 1'b1 || d.flush_ifid !== 1'b1 || d.id_jr !== 1'b0 || d.stall !== 1'b0) begin
            failures++;
            $display("FAIL jal_redirect got=%b%b%b%b exp=1100",
                     d.id_jump, d.flush_ifid, d.id_jr, d.stall);
        end
        issue('0, 1'b0, 1'b0);
        issue(itype(OP_ADDI, 1, 9, 16'h7), 1'b1, 1'b0);
        sb.push_back('{cyc + 3, 8'b1000_1001, 1'b0});
        issue(rtype(9, 0, 0, FN_JR), 1'b1, 1'b0);
        jstalls = 0;
        early = 1'b0;
        for (int i = 0; i < 8 && d.stall === 1'b1; i++) begin
            jstalls++;
            if (d.id_jump !== 1'b0) early = 1'b1;
            issue(rtype(9, 0, 0, FN_JR), 1'b1, 1'b0);
        end
        checks++;
        if (jstalls !== 3 || early !== 1'b0) begin
            failures++;
            $display("FAIL jr_stall got=%0d early=%b exp=3 early=0", jstalls, early);
        end
        checks++;
        if (d.id_jump !== 1'b1 || d.id_jr !== 1'b1 || d.flush_ifid !== 1'b1) begin
            failures++;
            $display("FAIL jr_redirect got=%b%b%b exp=111", d.id_jump, d.id_jr, d.flush_ifid);
        end
        issue('0, 1'b0, 1'b0);
        checks++;
        if (d_fcnt !== 16'd2) begin
            failures++; $display("FAIL jump_flush_cnt got=%0d exp=2", d_fcnt);
        end
        repeat (5) @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (wb_log[e.due % 1024] !== e.wb || mem_log[(e.due - 1) % 1024] !== e.mw) begin
                failures++;
                $display("FAIL jump_wb due=%0d got=%b/%b exp=%b/%b", e.due,
                         wb_log[e.due % 1024], mem_log[(e.due - 1) % 1024], e.wb, e.mw);
            end
        end
    endtask

    task automatic test_illegal();
        exp_t e;
        do_reset();
        issue(32'hfc00_0000, 1'b1, 1'b0);
        sb.push_back('{cyc + 3, 8'h00, 1'b0});
        checks++;
        if (d.illegal !== 1'b1) begin
            failures++; $display("FAIL illegal_op got=%b exp=1", d.illegal);
        end
        issue(itype(OP_ADDI, 1, 0, 16'h5), 1'b1, 1'b0);
        sb.push_back('{cyc + 3, 8'h00, 1'b0});
        checks++;
        if (d.illegal !== 1'b0) begin
            failures++; $display("FAIL illegal_one_cycle got=%b exp=0", d.illegal);
        end
        issue(rtype(1, 2, 3, 6'h00), 1'b1, 1'b0);
        sb.push_back('{cyc + 3, 8'h00, 1'b0});
        checks++;
        if (d.illegal !== 1'b1) begin
            failures++; $display("FAIL illegal_funct got=%b exp=1", d.illegal);
        end
        issue(itype(OP_SW, 1, 3, 16'h4), 1'b1, 1'b0);
        sb.push_back('{cyc + 3, 8'h00, 1'b1});
        issue(32'hfc00_0000, 1'b0, 1'b0);
        checks++;
        if (d.illegal !== 1'b0) begin
            failures++; $display("FAIL bubble_not_illegal got=%b exp=0", d.illegal);
        end
        repeat (5) @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (wb_log[e.due % 1024] !== e.wb || mem_log[(e.due - 1) % 1024] !== e.mw) begin
                failures++;
                $display("FAIL illegal_wb due=%0d got=%b/%b exp=%b/%b", e.due,
                         wb_log[e.due % 1024], mem_log[(e.due - 1) % 1024], e.wb, e.mw);
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            issue(itype(OP_LW, 1, 2, 16'h0), 1'b1, 1'b0);
            issue(rtype(2, 4, 3, FN_ADD), 1'b1, 1'b0);
            issue(rtype(2, 4, 3, FN_ADD), 1'b1, 1'b0);
        end
        issue('0, 1'b0, 1'b0);
        checks++;
        if (s_scnt !== 2'd3 || d_scnt !== 16'd4) begin
            failures++; $display("FAIL sat_hold got=%0d/%0d exp=3/4", s_scnt, d_scnt);
        end
        issue(itype(OP_LW, 1, 2, 16'h0), 1'b1, 1'b0);
        issue(rtype(2, 4, 3, FN_ADD), 1'b1, 1'b0);
        checks++;
        if (s.stall !== 1'b1) begin
            failures++; $display("FAIL sat_midstall got=%b exp=1", s.stall);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (s.stall !== 1'b0 || s_scnt !== 2'd0 || s_fcnt !== 2'd0) begin
            failures++;
            $display("FAIL reset_midstall got=%b/%0d/%0d exp=0/0/0", s.stall, s_scnt, s_fcnt);
        end
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (s.stall !== 1'b0 || s_scnt !== 2'd0) begin
            failures++;
            $display("FAIL post_reset_fresh got=%b/%0d exp=0/0", s.stall, s_scnt);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forward();
        test_branch();
        test_jump();
        test_illegal();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
